// File: rtl/ahb_slv_mem.sv
// AHB-Lite slave backed by a word-organised memory.
// Configurable wait states on OKAY transfers, two-cycle ERROR response for
// out-of-range, oversized or misaligned transfers, and byte-strobed writes.
module ahb_slv_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic [3:0]            hwstrb,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              cnt, cnt_nxt;
  logic                    accept;
  logic                    done;
  logic                    addr_err;
  logic                    out_rng;
  logic [ADDR_WIDTH-3:0]   word_idx;
  logic [IDX_W-1:0]        idx_p0;
  logic [1:0]              lo_p0;
  logic                    wr_p0;
  logic [2:0]              size_p0;
  logic [3:0]              lane;
  logic [3:0]              we_mask;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];
  logic                    unused_ok;

  // hburst carries no meaning for a simple memory slave
  assign unused_ok = ^hburst;

  assign word_idx = haddr[ADDR_WIDTH-1:2];
  assign out_rng  = (64'(word_idx) >= 64'(MEM_DEPTH));

  // Classify the address phase: range, size and alignment errors
  always_comb begin
    addr_err = out_rng;
    if (hsize > 3'd2)                          addr_err = 1'b1;
    if (hsize == 3'd1 && haddr[0])             addr_err = 1'b1;
    if (hsize == 3'd2 && haddr[1:0] != 2'b00)  addr_err = 1'b1;
  end

  // Next-state, wait counter and bus response; a free slot (hready=1)
  // immediately admits the next address phase, giving back-to-back transfers
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    hready    = 1'b1;
    hresp     = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: ;
      WAIT: begin
        if (cnt != 3'd0) begin
          hready  = 1'b0;
          cnt_nxt = cnt - 3'd1;
        end else begin
          done = 1'b1;
        end
      end
      ERR1: begin
        hready    = 1'b0;
        hresp     = 1'b1;
        state_nxt = ERR2;
      end
      ERR2: hresp = 1'b1;
      default: state_nxt = IDLE;
    endcase
    if (hready) begin
      if (hsel && htrans[1]) begin
        accept = 1'b1;
        if (addr_err) begin
          state_nxt = ERR1;
          cnt_nxt   = 3'd0;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = 3'(WAIT_STATES);
        end
      end else begin
        state_nxt = IDLE;
        cnt_nxt   = 3'd0;
      end
    end
  end

  // Control state: FSM and wait counter, asynchronously reset
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Address-phase capture for use in the data phase
  always_ff @(posedge hclk) begin
    if (accept) begin
      idx_p0  <= haddr[IDX_W+1:2];
      lo_p0   <= haddr[1:0];
      wr_p0   <= hwrite;
      size_p0 <= hsize;
    end
  end

  // Little-endian byte-lane selection from size and low address bits
  always_comb begin
    lane = 4'b0000;
    case (size_p0)
      3'd0:    lane = 4'b0001 << lo_p0;
      3'd1:    lane = lo_p0[1] ? 4'b1100 : 4'b0011;
      default: lane = 4'b1111;
    endcase
  end

  assign we_mask = lane & hwstrb;

  // Byte-masked memory update on the completing edge of a write
  always_ff @(posedge hclk) begin
    if (done && wr_p0) begin
      for (int i = 0; i < 4; i++) begin
        if (we_mask[i]) mem[idx_p0][8*i +: 8] <= hwdata[8*i +: 8];
      end
    end
  end

  // Read data only in the completing cycle of a read, zero otherwise
  assign hrdata = (done && !wr_p0) ? mem[idx_p0] : '0;

endmodule

// File: tb/tb_ahb_slv_mem.sv
// Directed bench for ahb_slv_mem: one zero-wait instance and one with two
// wait states share the bus signals and are told apart by their hsel.
module tb_ahb_slv_mem;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b1;
  logic        hsel0, hsel2;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [3:0]  hwstrb;
  logic [31:0] hrdata0, hrdata2;
  logic        hready0, hready2;
  logic        hresp0, hresp2;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NSEQ = 2'b10, T_SEQ = 2'b11;

  always #5 hclk = ~hclk;

  ahb_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb),
    .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
  );

  ahb_slv_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(2)) dut2 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel2), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hwstrb(hwstrb),
    .hrdata(hrdata2), .hready(hready2), .hresp(hresp2)
  );

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic ap(input logic s0, input logic s2, input logic [1:0] tr,
                    input logic [31:0] a, input logic w, input logic [2:0] sz);
    hsel0  = s0;
    hsel2  = s2;
    htrans = tr;
    haddr  = a;
    hwrite = w;
    hsize  = sz;
  endtask

  task automatic idle_ap();
    ap(1'b0, 1'b0, T_IDLE, 32'h0, 1'b0, 3'd2);
  endtask

  task automatic wr0(input logic [31:0] a, input logic [2:0] sz,
                     input logic [31:0] d, input logic [3:0] st);
    ap(1'b1, 1'b0, T_NSEQ, a, 1'b1, sz);
    tick();
    idle_ap();
    hwdata = d;
    hwstrb = st;
    tick();
  endtask

  task automatic rd0(input logic [31:0] a, output logic [31:0] d);
    ap(1'b1, 1'b0, T_NSEQ, a, 1'b0, 3'd2);
    tick();
    idle_ap();
    d = hrdata0;
    tick();
  endtask

  task automatic wr2(input logic [31:0] a, input logic [31:0] d, output logic ok);
    int n;
    ap(1'b0, 1'b1, T_NSEQ, a, 1'b1, 3'd2);
    tick();
    idle_ap();
    hwdata = d;
    hwstrb = 4'hF;
    n = 0;
    while (!hready2 && n < 10) begin
      tick();
      n++;
    end
    ok = hready2;
    tick();
  endtask

  task automatic rd2(input logic [31:0] a, output logic [31:0] d, output logic ok);
    int n;
    ap(1'b0, 1'b1, T_NSEQ, a, 1'b0, 3'd2);
    tick();
    idle_ap();
    n = 0;
    while (!hready2 && n < 10) begin
      tick();
      n++;
    end
    ok = hready2;
    d  = hrdata2;
    tick();
  endtask

  task automatic test_reset();
    idle_ap();
    hburst = 3'd0;
    hwdata = 32'h0;
    hwstrb = 4'h0;
    #2 hresetn = 1'b0;
    #2;
    tick();
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL reset_hready0 got %b want 1", hready0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL reset_hresp0 got %b want 0", hresp0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL reset_hrdata0 got %h want 0", hrdata0); end
    checks++; if (hready2 !== 1'b1) begin errors++; $display("FAIL reset_hready2 got %b want 1", hready2); end
    checks++; if (hresp2 !== 1'b0) begin errors++; $display("FAIL reset_hresp2 got %b want 0", hresp2); end
    checks++; if (hrdata2 !== 32'h0) begin errors++; $display("FAIL reset_hrdata2 got %h want 0", hrdata2); end
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    ap(1'b1, 1'b0, T_NSEQ, 32'h10, 1'b1, 3'd2);
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL b2b_hready_a got %b want 1", hready0); end
    tick();
    hwdata = 32'hDEADBEEF;
    hwstrb = 4'hF;
    ap(1'b1, 1'b0, T_NSEQ, 32'h10, 1'b0, 3'd2);
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL b2b_hready_wr got %b want 1", hready0); end
    tick();
    idle_ap();
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL b2b_hready_rd got %b want 1", hready0); end
    checks++; if (hrdata0 !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_rdata got %h want deadbeef", hrdata0); end
    tick();
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL b2b_rdata_idle got %h want 0", hrdata0); end
  endtask

  task automatic test_wait();
    logic ok;
    wr2(32'h30, 32'h12345678, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wait_wr_done got %b want 1", ok); end
    ap(1'b0, 1'b1, T_NSEQ, 32'h30, 1'b0, 3'd2);
    tick();
    checks++; if (hready2 !== 1'b0) begin errors++; $display("FAIL wait_w1_hready got %b want 0", hready2); end
    checks++; if (hrdata2 !== 32'h0) begin errors++; $display("FAIL wait_w1_rdata got %h want 0", hrdata2); end
    tick();
    checks++; if (hready2 !== 1'b0) begin errors++; $display("FAIL wait_w2_hready got %b want 0", hready2); end
    tick();
    checks++; if (hready2 !== 1'b1) begin errors++; $display("FAIL wait_done_hready got %b want 1", hready2); end
    checks++; if (hrdata2 !== 32'h12345678) begin errors++; $display("FAIL wait_done_rdata got %h want 12345678", hrdata2); end
    tick();
    idle_ap();
    checks++; if (hready2 !== 1'b0) begin errors++; $display("FAIL wait_pipe_accept got %b want 0", hready2); end
    tick();
    checks++; if (hready2 !== 1'b0) begin errors++; $display("FAIL wait_pipe_w2 got %b want 0", hready2); end
    tick();
    checks++; if (hready2 !== 1'b1) begin errors++; $display("FAIL wait_pipe_done got %b want 1", hready2); end
    checks++; if (hrdata2 !== 32'h12345678) begin errors++; $display("FAIL wait_pipe_rdata got %h want 12345678", hrdata2); end
    tick();
    checks++; if (hrdata2 !== 32'h0) begin errors++; $display("FAIL wait_idle_rdata got %h want 0", hrdata2); end
  endtask

  task automatic test_strobes();
    logic [31:0] d;
    wr0(32'h20, 3'd2, 32'h11223344, 4'hF);
    wr0(32'h22, 3'd0, 32'h00AA0000, 4'hF);
    rd0(32'h20, d);
    checks++; if (d !== 32'h11AA3344) begin errors++; $display("FAIL strb_byte got %h want 11aa3344", d); end
    wr0(32'h20, 3'd2, 32'hFFFFFFFF, 4'b0101);
    rd0(32'h20, d);
    checks++; if (d !== 32'h11FF33FF) begin errors++; $display("FAIL strb_mask got %h want 11ff33ff", d); end
    wr0(32'h62, 3'd1, 32'hBEEF0000, 4'hF);
    wr0(32'h60, 3'd1, 32'h0000CAFE, 4'hF);
    rd0(32'h60, d);
    checks++; if (d !== 32'hBEEFCAFE) begin errors++; $display("FAIL strb_half got %h want beefcafe", d); end
  endtask

  task automatic test_error();
    logic [31:0] d;
    ap(1'b1, 1'b0, T_NSEQ, 32'h400, 1'b0, 3'd2);
    tick();
    idle_ap();
    checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err_rng_e1_hresp got %b want 1", hresp0); end
    checks++; if (hready0 !== 1'b0) begin errors++; $display("FAIL err_rng_e1_hready got %b want 0", hready0); end
    checks++; if (hrdata0 !== 32'h0) begin errors++; $display("FAIL err_rng_rdata got %h want 0", hrdata0); end
    tick();
    checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err_rng_e2_hresp got %b want 1", hresp0); end
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL err_rng_e2_hready got %b want 1", hready0); end
    tick();
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL err_after_hresp got %b want 0", hresp0); end
    ap(1'b1, 1'b0, T_NSEQ, 32'h21, 1'b1, 3'd1);
    tick();
    idle_ap();
    hwdata = 32'hBBBBBBBB;
    hwstrb = 4'hF;
    checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err_mis_e1_hresp got %b want 1", hresp0); end
    checks++; if (hready0 !== 1'b0) begin errors++; $display("FAIL err_mis_e1_hready got %b want 0", hready0); end
    tick();
    checks++; if (hresp0 !== 1'b1) begin errors++; $display("FAIL err_mis_e2_hresp got %b want 1", hresp0); end
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL err_mis_e2_hready got %b want 1", hready0); end
    tick();
    rd0(32'h20, d);
    checks++; if (d !== 32'h11FF33FF) begin errors++; $display("FAIL err_mem_kept got %h want 11ff33ff", d); end
  endtask

  task automatic test_burst();
    logic [31:0] d;
    logic [31:0] exp_w [4];
    exp_w[0] = 32'hA0A0A0A0;
    exp_w[1] = 32'hB1B1B1B1;
    exp_w[2] = 32'hC2C2C2C2;
    exp_w[3] = 32'hD3D3D3D3;
    hburst = 3'b011;
    hwstrb = 4'hF;
    ap(1'b1, 1'b0, T_NSEQ, 32'h40, 1'b1, 3'd2);
    tick();
    hwdata = exp_w[0];
    ap(1'b1, 1'b0, T_BUSY, 32'h44, 1'b1, 3'd2);
    tick();
    hwdata = 32'h0BAD0BAD;
    checks++; if (hready0 !== 1'b1) begin errors++; $display("FAIL burst_busy_hready got %b want 1", hready0); end
    checks++; if (hresp0 !== 1'b0) begin errors++; $display("FAIL burst_busy_hresp got %b want 0", hresp0); end
    ap(1'b1, 1'b0, T_SEQ, 32'h44, 1'b1, 3'd2);
    tick();
    hwdata = exp_w[1];
    ap(1'b1, 1'b0, T_SEQ, 32'h48, 1'b1, 3'd2);
    tick();
    hwdata = exp_w[2];
    ap(1'b1, 1'b0, T_SEQ, 32'h4C, 1'b1, 3'd2);
    tick();
    hwdata = exp_w[3];
    idle_ap();
    tick();
    hburst = 3'd0;
    for (int i = 0; i < 4; i++) begin
      rd0(32'h40 + 32'(4 * i), d);
      checks++; if (d !== exp_w[i]) begin errors++; $display("FAIL burst_word%0d got %h want %h", i, d, exp_w[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic ok;
    wr2(32'h50, 32'hCAFEF00D, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_pre_done got %b want 1", ok); end
    ap(1'b0, 1'b1, T_NSEQ, 32'h50, 1'b1, 3'd2);
    tick();
    idle_ap();
    hwdata = 32'h0BADBEEF;
    hwstrb = 4'hF;
    checks++; if (hready2 !== 1'b0) begin errors++; $display("FAIL rstmid_wait got %b want 0", hready2); end
    #2 hresetn = 1'b0;
    #1;
    checks++; if (hready2 !== 1'b1) begin errors++; $display("FAIL rstmid_hready got %b want 1", hready2); end
    checks++; if (hresp2 !== 1'b0) begin errors++; $display("FAIL rstmid_hresp got %b want 0", hresp2); end
    tick();
    tick();
    hresetn = 1'b1;
    tick();
    rd2(32'h50, d, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_rd_done got %b want 1", ok); end
    checks++; if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_kept got %h want cafef00d", d); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_wait();
    test_strobes();
    test_error();
    test_burst();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_slv_mem.md
AHB_SLV_MEM -- requirements
Module: ahb_slv_mem

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the haddr width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the hwdata/hrdata width; only 32 is supported.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 256, giving the number of 32-bit words.
REQ-004 The block SHALL have parameter WAIT_STATES, default 0 (range 0..7), giving the extra data-phase cycles inserted on every OKAY transfer.
REQ-005 The block SHALL have port hclk, input, 1 bit: the single clock; all logic SHALL be clocked on the rising edge.
REQ-006 The block SHALL have port hresetn, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port hsel, input, 1 bit: slave select.
REQ-008 The block SHALL have port haddr, input, ADDR_WIDTH bits: byte address.
REQ-009 The block SHALL have port htrans, input, 2 bits: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-010 The block SHALL have port hwrite, input, 1 bit: 1 = write.
REQ-011 The block SHALL have port hsize, input, 3 bits: transfer size.
REQ-012 The block SHALL have port hburst, input, 3 bits: burst type; it is informational only.
REQ-013 The block SHALL have port hwdata, input, 32 bits: write data, sampled in the data phase.
REQ-014 The block SHALL have port hwstrb, input, 4 bits: write byte strobes, sampled in the data phase.
REQ-015 The block SHALL have port hrdata, output, 32 bits: read data.
REQ-016 The block SHALL have port hready, output, 1 bit: transfer done; also taken as the bus-level HREADY input.
REQ-017 The block SHALL have port hresp, output, 1 bit: 0 = OKAY, 1 = ERROR.

Function
REQ-018 The block SHALL accept an address phase only when hsel=1, hready=1 and htrans is NONSEQ or SEQ; it SHALL register haddr, hwrite and hsize at that edge.
REQ-019 For IDLE, BUSY or hsel=0, the next cycle SHALL be a zero-wait OKAY (hready=1, hresp=0) with no memory access.
REQ-020 The FSM SHALL have the states IDLE, WAIT, ERR1 and ERR2.
REQ-021 On an accepted valid transfer, the FSM SHALL go to WAIT with a counter set to WAIT_STATES; hready SHALL be 0 while the counter is nonzero, and the counter SHALL decrement each cycle.
REQ-022 When the counter reaches 0, hready SHALL be 1 and hresp 0, completing the transfer; with WAIT_STATES=0 the transfer SHALL complete in the first data-phase cycle.
REQ-023 A transfer is an error when any of these holds: word index haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH; hsize > 2; or haddr is misaligned for hsize (halfword: haddr[0]=1; word: haddr[1:0] != 0).
REQ-024 An erroring transfer SHALL take the sequence ERR1 (hresp=1, hready=0) then ERR2 (hresp=1, hready=1), with no wait states, and SHALL NOT modify memory.
REQ-025 Write lane mask SHALL be the size/address lane mask ANDed with hwstrb: byte = 1 lane at haddr[1:0]; halfword = lanes {haddr[1],0} and {haddr[1],1}; word = all 4 lanes; little-endian.
REQ-026 Writes SHALL update only the masked bytes of mem[index] on the completing edge (hready=1 cycle).
REQ-027 Reads SHALL drive the full 32-bit mem[index] on hrdata in the completing cycle; hrdata SHALL be 0 in every other cycle.
REQ-028 Pipelining: a new address phase presented in a completing cycle (hready=1, including ERR2) SHALL be accepted at that same edge, giving back-to-back transfers.
REQ-029 Read-after-write to the same word in consecutive transfers SHALL return the newly written data.
REQ-030 Address-phase signals SHALL be ignored while hready=0.

Reset
REQ-031 While hresetn=0, the FSM SHALL be IDLE, the wait counter 0, hready=1, hresp=0 and hrdata=0; memory contents SHALL NOT be reset.
REQ-032 Reset asserted mid-transfer SHALL abort the transfer with no memory write; outputs SHALL take reset values immediately (asynchronously).

Verification
REQ-033 WAIT_STATES=0: write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> hready=1 every cycle, hrdata=0xDEADBEEF in the read data phase.
REQ-034 WAIT_STATES=2: single read -> hready low for 2 cycles, then high with data; the next NONSEQ held stable is accepted on the completing edge.
REQ-035 Word 0x11223344 at 0x20, then byte write 0xAA to 0x22, then word read -> 0x11AA3344; repeat the word write with hwstrb=0101 over 0xFFFFFFFF -> 0x11FF33FF.
REQ-036 Read of 0x400 (MEM_DEPTH=256), then halfword at 0x21 -> each gives ERR1 (hresp=1, hready=0), ERR2 (hresp=1, hready=1); memory unchanged.
REQ-037 NONSEQ, BUSY, SEQ incrementing burst of 4 words -> BUSY yields a zero-wait OKAY with no access, and all 4 words are written correctly.
REQ-038 hresetn pulled low during a WAIT cycle of a write -> hready=1, hresp=0 immediately; the target word keeps its old value.
